pmem_arbiter: RTL and testbench

Shares the single burst physical-memory port of `mp4` between the instruction cache and the data cache. It accepts whole-line requests (256 bits) from each cache, picks one with round-robin arbitration, and runs a 4-beat, 64-bit burst on the pmem port. It assembles read beats into a line, or serialises a write-back line into beats, then returns one `resp` pulse to the granted cache. It sits between `i_cache`/`d_cache` and the top-level `pmem_*` ports.

---
 rtl/pmem_arbiter.sv | 115 +++++++++++
 tb/tb_pmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing the burst pmem port between I-cache and D-cache.
// Whole 256-bit lines are moved as four 64-bit beats; one resp pulse per line.
module pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int SH_W  = $clog2(BEAT_W);
    localparam int IDX_W = $clog2(LINE_W);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat;
    logic [IDX_W-1:0]  beat_lsb;
    logic [LINE_W-1:0] line_buf;
    logic              last_d;
    logic              d_req;
    logic              pick_d;
    logic [ADDR_W-1:0] grant_addr;
    logic [OFF_W-1:0]  unused_offset;

    // On contention the side that was not served last wins; last_d resets to I.
    assign d_req         = d_read | d_write;
    assign pick_d        = d_req & (~i_read | ~last_d);
    assign grant_addr    = pick_d ? d_address : i_address;
    assign unused_offset = grant_addr[OFF_W-1:0];

    assign beat_lsb   = {beat, {SH_W{1'b0}}};
    assign pmem_wdata = line_buf[beat_lsb +: BEAT_W];
    assign i_rdata    = line_buf;
    assign d_rdata    = line_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            beat         <= '0;
            line_buf     <= '0;
            last_d       <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_read | d_req) begin
                        pmem_address <= {grant_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        beat         <= '0;
                        last_d       <= pick_d;
                        if (pick_d && d_write) begin
                            line_buf   <= d_wdata;
                            pmem_write <= 1'b1;
                            state      <= D_WR;
                        end else begin
                            pmem_read <= 1'b1;
                            state     <= pick_d ? D_RD : I_RD;
                        end
                    end
                end
                I_RD, D_RD: begin
                    if (pmem_resp) begin
                        line_buf[beat_lsb +: BEAT_W] <= pmem_rdata;
                        beat <= beat + CNT_W'(1);
                        if (beat == LAST_BEAT) begin
                            pmem_read <= 1'b0;
                            i_resp    <= (state == I_RD);
                            d_resp    <= (state == D_RD);
                            state     <= DONE;
                        end
                    end
                end
                D_WR: begin
                    if (pmem_resp) begin
                        beat <= beat + CNT_W'(1);
                        if (beat == LAST_BEAT) begin
                            pmem_write <= 1'b0;
                            d_resp     <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                // One-cycle bubble so a cache can drop its request before IDLE samples again.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios followed by randomized cache/pmem traffic
// checked against a transaction-level arbitration and line-assembly model.
module tb_pmem_arbiter;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    pmem_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (i_resp) i_pulses <= i_pulses + 1;
        if (d_resp) d_pulses <= d_pulses + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Acts as pmem for one burst whose command is already up; optional gap before beat gap_at.
    task automatic serve(input logic wr, input logic [255:0] line, input int gap_at,
                         input int gap_len, input logic [31:0] addr);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    pmem_resp = 1'b0;
                    tick();
                    chk("gap_cmd", 256'(wr ? pmem_write : pmem_read), 256'(1));
                    chk("gap_addr", 256'(pmem_address), 256'(addr));
                end
            end
            pmem_resp  = 1'b1;
            pmem_rdata = line[k*64 +: 64];
            if (wr) chk("wbeat", 256'(pmem_wdata), 256'(line[k*64 +: 64]));
            tick();
        end
        pmem_resp = 1'b0;
    endtask

    function automatic logic [63:0] mem_beat(input logic [31:0] a, input logic [31:0] k);
        return {a ^ 32'hA5A5_0000, a + k * 32'h0101_0101};
    endfunction

    // Reference model state for the random phase
    logic         active, act_d, act_wr, last_d, i_drop, d_drop;
    int           beats;
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;

    task automatic step(input logic draining);
        logic        exp_d;
        logic [31:0] a;
        chk("i_resp", 256'(i_resp), 256'(active && beats == 4 && !act_d));
        chk("d_resp", 256'(d_resp), 256'(active && beats == 4 && act_d));
        if (active && beats == 4) begin
            chk("cmd_drop", 256'({pmem_read, pmem_write}), 256'(0));
            if (!act_wr) chk("rdata", act_d ? d_rdata : i_rdata, exp_line);
            active = 1'b0;
            if (act_d) d_drop = 1'b1; else i_drop = 1'b1;
        end else if (!active && (pmem_read || pmem_write)) begin
            exp_d  = (d_read | d_write) && (!i_read || !last_d);
            act_d  = exp_d;
            act_wr = exp_d && d_write;
            last_d = exp_d;
            beats  = 0;
            active = 1'b1;
            a        = exp_d ? d_address : i_address;
            exp_addr = a & ~32'h1f;
            chk("start_wr", 256'(pmem_write), 256'(act_wr));
            chk("start_rd", 256'(pmem_read), 256'(!act_wr));
            chk("start_addr", 256'(pmem_address), 256'(exp_addr));
            if (act_wr) exp_line = d_wdata;
            else for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = mem_beat(exp_addr, k);
        end else if (active) begin
            chk("hold_cmd", 256'({pmem_read, pmem_write}), 256'({!act_wr, act_wr}));
            chk("hold_addr", 256'(pmem_address), 256'(exp_addr));
        end

        if (active && beats < 4) begin
            pmem_resp  = ($urandom_range(0, 3) != 0);
            pmem_rdata = {$urandom, $urandom};
            if (pmem_resp) begin
                if (act_wr) chk("wdata", 256'(pmem_wdata), 256'(exp_line[beats*64 +: 64]));
                else pmem_rdata = exp_line[beats*64 +: 64];
                beats++;
            end
        end else begin
            pmem_resp  = ($urandom_range(0, 7) == 0);
            pmem_rdata = {$urandom, $urandom};
        end

        if (i_drop) begin
            i_read = 1'b0;
            i_drop = 1'b0;
        end else if (!i_read && !draining && $urandom_range(0, 2) == 0) begin
            i_read    = 1'b1;
            i_address = $urandom;
        end
        if (d_drop) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            d_drop  = 1'b0;
        end else if (!(d_read || d_write) && !draining && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
                0:       begin d_read = 1'b1; d_write = 1'b0; end
                1:       begin d_read = 1'b0; d_write = 1'b1; end
                default: begin d_read = 1'b1; d_write = 1'b1; end
            endcase
            d_address = $urandom;
            d_wdata   = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line;
        int c0;
        int p0;
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        rst = 1'b0;
        tick();
        tick();
        chk("rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_pmem_addr", 256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata", 256'(pmem_wdata), 256'(0));
        chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
        chk("rst_i_rdata", i_rdata, 256'(0));
        chk("rst_d_rdata", d_rdata, 256'(0));
        rst = 1'b1;
        tick();

        // I-cache fill, gap-free
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        p0 = d_pulses;
        i_read = 1'b1; i_address = 32'h0000_0064; c0 = cyc;
        tick();
        chk("ifill_cmd", 256'({pmem_read, pmem_write}), 256'(2'b10));
        chk("ifill_addr", 256'(pmem_address), 256'(32'h0000_0060));
        serve(1'b0, line, 4, 0, 32'h0000_0060);
        chk("ifill_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        chk("ifill_lat", 256'(cyc - c0), 256'(5));
        chk("ifill_data", i_rdata, line);
        chk("ifill_cmd_drop", 256'(pmem_read), 256'(0));
        tick();
        i_read = 1'b0;
        chk("ifill_pulse", 256'(i_resp), 256'(0));
        tick();
        chk("ifill_no_d", 256'(d_pulses), 256'(p0));

        // D-cache write-back
        line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = line;
        tick();
        chk("wb_cmd", 256'({pmem_read, pmem_write}), 256'(2'b01));
        chk("wb_addr", 256'(pmem_address), 256'(32'h8000_0020));
        serve(1'b1, line, 4, 0, 32'h8000_0020);
        chk("wb_cmd_drop", 256'(pmem_write), 256'(0));
        chk("wb_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        tick();
        d_write = 1'b0;
        chk("wb_pulse", 256'(d_resp), 256'(0));
        tick();

        // Contention straight out of reset: D first, then I
        do_reset();
        i_read = 1'b1; i_address = 32'h0000_1000;
        d_read = 1'b1; d_address = 32'h0000_2047;
        tick();
        chk("cont_first_addr", 256'(pmem_address), 256'(32'h0000_2040));
        line = {mem_beat(32'h2040, 3), mem_beat(32'h2040, 2), mem_beat(32'h2040, 1), mem_beat(32'h2040, 0)};
        serve(1'b0, line, 4, 0, 32'h0000_2040);
        chk("cont_first_resp", 256'({i_resp, d_resp}), 256'(2'b01));
        chk("cont_first_data", d_rdata, line);
        tick();
        d_read = 1'b0;
        chk("cont_idle_resp", 256'({i_resp, d_resp}), 256'(0));
        tick();
        chk("cont_second_addr", 256'(pmem_address), 256'(32'h0000_1000));
        line = {mem_beat(32'h1000, 3), mem_beat(32'h1000, 2), mem_beat(32'h1000, 1), mem_beat(32'h1000, 0)};
        serve(1'b0, line, 4, 0, 32'h0000_1000);
        chk("cont_second_resp", 256'({i_resp, d_resp}), 256'(2'b10));
        chk("cont_second_data", i_rdata, line);
        tick();
        i_read = 1'b0;
        tick();

        // Three idle cycles mid-burst stretch latency by three
        line = {mem_beat(32'h3000, 3), mem_beat(32'h3000, 2), mem_beat(32'h3000, 1), mem_beat(32'h3000, 0)};
        i_read = 1'b1; i_address = 32'h0000_3000; c0 = cyc;
        tick();
        serve(1'b0, line, 2, 3, 32'h0000_3000);
        chk("gap_resp", 256'(i_resp), 256'(1));
        chk("gap_lat", 256'(cyc - c0), 256'(8));
        chk("gap_data", i_rdata, line);
        tick();
        i_read = 1'b0;
        tick();

        // Reset during a write (read+write together acts as write)
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        p0 = d_pulses;
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_4000; d_wdata = line;
        tick();
        chk("rw_prec", 256'({pmem_read, pmem_write}), 256'(2'b01));
        for (int k = 0; k < 2; k++) begin
            pmem_resp = 1'b1;
            chk("abort_wbeat", 256'(pmem_wdata), 256'(line[k*64 +: 64]));
            tick();
        end
        pmem_resp = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_cmd_async", 256'(pmem_write), 256'(0));
        chk("abort_resp", 256'(d_resp), 256'(0));
        tick();
        d_read = 1'b0; d_write = 1'b0; rst = 1'b1;
        tick();
        chk("abort_no_dresp", 256'(d_pulses), 256'(p0));
        line = {mem_beat(32'h5000, 3), mem_beat(32'h5000, 2), mem_beat(32'h5000, 1), mem_beat(32'h5000, 0)};
        i_read = 1'b1; i_address = 32'h0000_5000;
        tick();
        chk("post_abort_cmd", 256'({pmem_read, pmem_write}), 256'(2'b10));
        serve(1'b0, line, 4, 0, 32'h0000_5000);
        chk("post_abort_data", i_rdata, line);
        chk("post_abort_resp", 256'(i_resp), 256'(1));
        tick();
        i_read = 1'b0;
        tick();

        // Stray pmem_resp while idle
        for (int k = 0; k < 3; k++) begin
            pmem_resp = 1'b1;
            tick();
            chk("spur_cmd", 256'({pmem_read, pmem_write}), 256'(0));
            chk("spur_resp", 256'({i_resp, d_resp}), 256'(0));
        end
        pmem_resp = 1'b0;
        tick();

        // Random traffic; last grant before this point was I
        active = 0; act_d = 0; act_wr = 0; last_d = 0; i_drop = 0; d_drop = 0; beats = 0;
        exp_line = '0; exp_addr = '0;
        for (int n = 0; n < 3000; n++) step(1'b0);
        for (int n = 0; n < 300 && (active || i_read || d_read || d_write); n++) step(1'b1);
        chk("drain", 256'({active, i_read, d_read, d_write}), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
